crypto_round_sequencer: RTL

- Parametrised control sequencer for the cryptographic core; the next generation of the core's fixed-round control FSM.
- Issues one datapath operation at a time (load, add-key, sub-bytes, shift-rows, mix-columns, key-expand, save, output) over a valid/ack handshake, so datapath units may take a variable number of cycles.
- Supports a configurable round count, encrypt and decrypt modes, abort, ack timeout and illegal-mode error reporting.
- Sits between the processor-side command interface and the crypto datapath.

---
 rtl/crypto_round_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/crypto_round_sequencer.sv
// crypto_round_sequencer
//   Control sequencer for the cryptographic core. It issues one datapath op
//   at a time over a valid/ack handshake and walks the encrypt or decrypt
//   op schedule for NUM_ROUNDS rounds. It also handles abort, an optional
//   ack timeout and illegal-mode reporting.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low
//   start     in   begin an operation (sampled only in IDLE)
//   mode      in   01 encrypt, 10 decrypt, 00/11 illegal
//   abort     in   synchronous cancel of a running operation
//   op_ack    in   datapath accepts/completes the current op
//   op_valid  out  op_code/op_inv/round are valid
//   op_code   out  0 LOAD .. 8 OUT_KEY
//   op_inv    out  inverse transform select (decrypt)
//   round     out  round index of the current op
//   busy      out  operation in progress (ISSUE and DONE)
//   done      out  one-cycle completion pulse
//   err       out  one-cycle pulse on illegal mode, abort or timeout
module crypto_round_sequencer #(
  parameter int NUM_ROUNDS  = 4,
  parameter int CNT_W       = 3,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             abort,
  input  logic             op_ack,
  output logic             op_valid,
  output logic [3:0]       op_code,
  output logic             op_inv,
  output logic [CNT_W-1:0] round,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_R   = CNT_W'(NUM_ROUNDS);
  localparam logic [TW-1:0]    TMO_LAST = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {PH_PRE, PH_RND, PH_POST} phase_t;
  typedef enum logic [3:0] {
    OP_LOAD       = 4'd0,
    OP_ADD_KEY    = 4'd1,
    OP_SUB_BYTES  = 4'd2,
    OP_SHIFT_ROWS = 4'd3,
    OP_MIX_COLS   = 4'd4,
    OP_KEY_EXPAND = 4'd5,
    OP_SAVE       = 4'd6,
    OP_OUT_DATA   = 4'd7,
    OP_OUT_KEY    = 4'd8
  } op_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic             inv_q, inv_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  op_t  cur_op;
  logic last_rnd;
  logic skip_mix;
  logic tmo;

  // Final round of the schedule: NUM_ROUNDS for encrypt, 1 for decrypt.
  assign last_rnd = inv_q ? (round_q == CNT_W'(1)) : (round_q == LAST_R);
  // MIX_COLS sits at step 3 (encrypt) / step 4 (decrypt) and is dropped in
  // the final round, so the step before it jumps by two.
  assign skip_mix = last_rnd && (step_q == (inv_q ? 3'd3 : 3'd2));
  assign tmo      = (ACK_TIMEOUT > 0) && (state_q == S_ISSUE) && !op_ack
                    && (tcnt_q == TMO_LAST);

  always_comb begin
    cur_op = OP_LOAD;
    case (phase_q)
      PH_PRE:  cur_op = (step_q == 3'd0) ? OP_LOAD : OP_ADD_KEY;
      PH_RND: begin
        if (!inv_q) begin
          case (step_q)
            3'd0:    cur_op = OP_SAVE;
            3'd1:    cur_op = OP_SUB_BYTES;
            3'd2:    cur_op = OP_SHIFT_ROWS;
            3'd3:    cur_op = OP_MIX_COLS;
            3'd4:    cur_op = OP_KEY_EXPAND;
            default: cur_op = OP_ADD_KEY;
          endcase
        end else begin
          case (step_q)
            3'd0:    cur_op = OP_SHIFT_ROWS;
            3'd1:    cur_op = OP_SUB_BYTES;
            3'd2:    cur_op = OP_KEY_EXPAND;
            3'd3:    cur_op = OP_ADD_KEY;
            3'd4:    cur_op = OP_MIX_COLS;
            default: cur_op = OP_SAVE;
          endcase
        end
      end
      PH_POST: cur_op = (step_q == 3'd0) ? OP_OUT_DATA : OP_OUT_KEY;
      default: cur_op = OP_LOAD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    round_d = round_q;
    inv_d   = inv_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode == 2'b01 || mode == 2'b10) begin
            state_d = S_ISSUE;
            phase_d = PH_PRE;
            step_d  = '0;
            inv_d   = (mode == 2'b10);
            round_d = (mode == 2'b10) ? LAST_R : '0;
            tcnt_d  = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ISSUE: begin
        // Abort and timeout take priority over a coincident ack.
        if (abort || tmo) begin
          state_d = S_ERR;
          round_d = '0;
          tcnt_d  = '0;
        end else if (op_ack) begin
          tcnt_d = '0;
          case (phase_q)
            PH_PRE: begin
              if (step_q == 3'd0) begin
                step_d = 3'd1;
              end else begin
                phase_d = PH_RND;
                step_d  = '0;
                round_d = inv_q ? LAST_R : CNT_W'(1);
              end
            end
            PH_RND: begin
              if (step_q == 3'd5) begin
                step_d = '0;
                if (last_rnd) begin
                  phase_d = PH_POST;
                  round_d = inv_q ? '0 : LAST_R;
                end else begin
                  round_d = inv_q ? round_q - CNT_W'(1) : round_q + CNT_W'(1);
                end
              end else begin
                step_d = skip_mix ? step_q + 3'd2 : step_q + 3'd1;
              end
            end
            default: begin
              if (step_q == 3'd0) begin
                step_d = 3'd1;
              end else begin
                state_d = S_DONE;
              end
            end
          endcase
        end else if (ACK_TIMEOUT > 0) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        round_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_PRE;
      step_q  <= '0;
      round_q <= '0;
      inv_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      round_q <= round_d;
      inv_q   <= inv_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign op_valid = (state_q == S_ISSUE);
  assign op_code  = op_valid ? cur_op : OP_LOAD;
  assign op_inv   = op_valid && inv_q;
  assign round    = round_q;
  assign busy     = (state_q == S_ISSUE) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);

endmodule
